// File: rtl/branch_redirect_pkg.sv
// Shared types for the execute-stage redirect path: operand widths, control-transfer
// opcodes and the redirect bundle that fetch PC selection consumes.
package branch_redirect_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_BRANCH = 2'd1,
        BR_JAL    = 2'd2,
        BR_JALR   = 2'd3
    } br_op_t;

    typedef struct packed {
        u1  jump;
        u64 pcsrc;
    } redirect_t;

    // Jumps always transfer control; a conditional branch only when its compare succeeded.
    function automatic u1 wants_redirect(input br_op_t op, input u1 taken);
        return (op == BR_JAL) || (op == BR_JALR) || ((op == BR_BRANCH) && taken);
    endfunction

endpackage

// File: rtl/branch_redirect_target.sv
// Combinational control-transfer target and link computation (BRANCH/JAL/JALR),
// all arithmetic modulo 2^64.
module branch_redirect_target
    import branch_redirect_pkg::*;
(
    input  br_op_t      op,
    input  logic [63:0] pc,
    input  logic [63:0] rs1,
    input  logic [63:0] imm,
    output logic [63:0] target,
    output logic [63:0] link
);

    u64 base;

    // NOTE: every combinational output gets a value before any conditional override, so no latch is inferred.
    always_comb begin
        base   = (op == BR_JALR) ? rs1 : pc;
        target = base + imm;
        if (op == BR_JALR) begin
            target[0] = 1'b0;
        end
    end

    assign link = pc + 64'd4;

endmodule

// File: rtl/branch_redirect.sv
// Execute-stage redirect resolver: holds a redirect while fetch is stalled and flushes
// younger stages. Optional redirect counter enabled by BRANCH_REDIRECT_PERF_EN.
module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic [1:0]        ex_op,
    input  logic              ex_taken,
    input  logic [63:0]       ex_pc,
    input  logic [63:0]       ex_rs1,
    input  logic [63:0]       ex_imm,
    input  logic              fetch_stall,
    output logic              jump,
    output logic [63:0]       pcsrc,
    output logic              flush,
    output logic [63:0]       link,
    output logic              busy
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [CNT_W-1:0]  redirect_cnt
`endif
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    u64         tgt_q;
    u64         target;
    u1          redir_now;
    redirect_t  redir;
    br_op_t     op;

    assign op = br_op_t'(ex_op);

    branch_redirect_target u_target (
        .op     (op),
        .pc     (ex_pc),
        .rs1    (ex_rs1),
        .imm    (ex_imm),
        .target (target),
        .link   (link)
    );

    assign redir_now = ex_valid && wants_redirect(op, ex_taken) && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        redir.jump  = 1'b0;
        redir.pcsrc = '0;
        if (state_q == ST_PENDING) begin
            // Wrong-path ex_valid pulses are dropped while the held redirect waits for fetch.
            redir.jump  = 1'b1;
            redir.pcsrc = tgt_q;
            if (!fetch_stall) begin
                state_d = ST_IDLE;
            end
        end else if (redir_now) begin
            redir.jump  = 1'b1;
            redir.pcsrc = target;
            if (fetch_stall) begin
                state_d = ST_PENDING;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redir_now && fetch_stall) begin
                tgt_q <= target;
            end
        end
    end

    assign jump  = redir.jump;
    assign pcsrc = redir.pcsrc;
    assign flush = redir.jump;
    assign busy  = (state_q == ST_PENDING);

`ifdef BRANCH_REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_cnt <= '0;
        end else if (redir.jump && !fetch_stall) begin
            redirect_cnt <= redirect_cnt + 1'b1;
        end
    end
`endif

endmodule
